counter_checker: RTL and testbench
==================================

COUNTER_CHECKER -- requirements
Module: counter_checker

Interface
REQ-001 The parameter list SHALL be: WIDTH, default 8, width of the observed counter value.
REQ-002 The parameter list SHALL also include: LOCK_CYCLES, default 2, number of consecutive correct increments needed to lock (range 1..15).
REQ-003 The parameter list SHALL also include: ERR_W, default 8, width of the error counter.
REQ-004 clk  input  1  rising-edge clock, shared with the observed counter.
REQ-005 reset  input  1  checker reset, synchronous, active-low.
REQ-006 value  input  WIDTH  observed counter output, sampled every rising edge.
REQ-007 cnt_reset  input  1  observed counter's own reset (active-high, synchronous), sampled alongside value.
REQ-008 locked  output  1  high while in LOCKED state.
REQ-009 err  output  1  one-cycle pulse on a detected sequence error.
REQ-010 err_sticky  output  1  set on first error; cleared only by reset.
REQ-011 err_count  output  ERR_W  saturating count of errors.
REQ-012 last_bad  output  WIDTH  value sampled on the most recent error.
REQ-013 wrap_count  output  16  count of observed max-to-0 wraps while locked (present only with the macro).

Function
REQ-014 The design SHALL be a registered checker: all outputs driven from flops; an error in sample n SHALL assert err in the cycle after edge n.
REQ-015 The design SHALL hold prev (WIDTH bits), which SHALL capture value on every edge except as stated in REQ-020.
REQ-016 The expected next value SHALL be prev+1 modulo 2^WIDTH; max followed by 0 is correct, and a held value (value==prev) is an error.
REQ-017 The states SHALL be UNLOCKED, ACQUIRE, LOCKED and FAULT.
REQ-018 UNLOCKED SHALL capture prev, clear match_cnt and go to ACQUIRE next edge.
REQ-019 In ACQUIRE, a correct value SHALL increment match_cnt; on reaching LOCK_CYCLES the state SHALL go to LOCKED, and on mismatch match_cnt SHALL clear with the state staying in ACQUIRE; ACQUIRE SHALL never raise err.
REQ-020 A sampled cnt_reset=1 SHALL take priority over everything: state goes to ACQUIRE, match_cnt clears, prev is loaded with 0 and no error is raised that cycle.
REQ-021 In LOCKED, a correct value SHALL keep the state in LOCKED.
REQ-022 In LOCKED, a mismatch SHALL pulse err, set err_sticky, load last_bad with value, increment err_count (saturating at 2^ERR_W-1) and go to FAULT.
REQ-023 FAULT SHALL last exactly one cycle, with its sample not checked and prev updated, and then go to ACQUIRE.
REQ-024 locked SHALL deassert in the cycle after the error sample.

Reset
REQ-025 With reset low at an edge: state UNLOCKED, prev=0, match_cnt=0, locked=0, err=0, err_sticky=0, err_count=0, last_bad=0, wrap_count=0.
REQ-026 Reset low mid-operation SHALL abort any state within one edge, with no err pulse on that edge.
REQ-027 reset SHALL dominate cnt_reset.

Configuration
REQ-028 The macro COUNTER_CHECKER_WRAP_CNT_EN SHALL control the wrap counter.
REQ-029 With the macro defined, in LOCKED with prev=2^WIDTH-1 and value=0, wrap_count SHALL increment, wrapping at 16 bits.
REQ-030 Without the macro, the wrap_count port and its logic SHALL be absent.

Structure
REQ-031 A shared package SHALL hold the state encoding typedef (2-bit enum) and the constant LOCK_CNT_W=4.
REQ-032 A single sub-module, sat_counter (parameterized width, inc, sync active-low clear), SHALL implement err_count.

Verification
REQ-033 The bench SHALL cover a free-running count: reset low 2 cycles, then value 0,1,2,3,4 -> locked=1 after sample 2 (edge 3), err never asserted.
REQ-034 The bench SHALL cover a skip: locked at value 0x10, next value 0x12 -> err=1 for one cycle, last_bad=0x12, err_count=1, err_sticky=1, locked=0, relock after 2 further correct increments.
REQ-035 The bench SHALL cover a wrap: locked, value 0xFE,0xFF,0x00,0x01 -> no err; wrap_count=1 with the macro.
REQ-036 The bench SHALL cover a counter reset: locked at 0x2A, cnt_reset=1 for 1 cycle, value 0x00,0x01,0x02 -> no err, relock.
REQ-037 The bench SHALL cover a hold: locked at 0x05, value 0x05 again -> err pulse, err_count=1; with 255 more errors err_count stays 0xFF.
REQ-038 The bench SHALL cover a mid-operation reset: reset low while in FAULT -> all outputs zero next edge, err_sticky=0.

Source files
------------

// File: rtl/counter_checker_pkg.sv
// Shared definitions for counter_checker: FSM state encoding and match counter width.
package counter_checker_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2,
        FAULT    = 2'd3
    } state_t;

    localparam int unsigned LOCK_CNT_W = 4;

endpackage

// File: rtl/counter_checker_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/counter_checker.sv
// Registered sequence checker for an observed free-running counter.
// Define COUNTER_CHECKER_WRAP_CNT_EN to add the wrap_count port and its counter.
module counter_checker #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned LOCK_CYCLES = 2,
    parameter int unsigned ERR_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] value,
    input  logic             cnt_reset,
    output logic             locked,
    output logic             err,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] last_bad
`ifdef COUNTER_CHECKER_WRAP_CNT_EN
    ,
    output logic [15:0]      wrap_count
`endif
);

    import counter_checker_pkg::*;

    state_t                  state, state_nxt;
    logic [WIDTH-1:0]        prev, prev_nxt;
    logic [LOCK_CNT_W-1:0]   match_cnt, match_cnt_nxt;
    logic                    err_nxt;
    logic                    wrap_hit;
    logic                    correct;

    assign correct = (value == (prev + WIDTH'(1)));

    always_comb begin
        state_nxt     = state;
        prev_nxt      = value;
        match_cnt_nxt = match_cnt;
        err_nxt       = 1'b0;
        wrap_hit      = 1'b0;
        // The observed counter's own reset overrides any checking this cycle.
        if (cnt_reset) begin
            state_nxt     = ACQUIRE;
            prev_nxt      = '0;
            match_cnt_nxt = '0;
        end else begin
            case (state)
                UNLOCKED: begin
                    match_cnt_nxt = '0;
                    state_nxt     = ACQUIRE;
                end
                ACQUIRE: begin
                    if (correct) begin
                        match_cnt_nxt = match_cnt + LOCK_CNT_W'(1);
                        if (match_cnt_nxt == LOCK_CNT_W'(LOCK_CYCLES)) begin
                            state_nxt = LOCKED;
                        end
                    end else begin
                        match_cnt_nxt = '0;
                    end
                end
                LOCKED: begin
                    if (!correct) begin
                        err_nxt   = 1'b1;
                        state_nxt = FAULT;
                    end else if (prev == '1) begin
                        wrap_hit = 1'b1;
                    end
                end
                FAULT: begin
                    match_cnt_nxt = '0;
                    state_nxt     = ACQUIRE;
                end
                default: begin
                    state_nxt = UNLOCKED;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= UNLOCKED;
            prev       <= '0;
            match_cnt  <= '0;
            locked     <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
            last_bad   <= '0;
        end else begin
            state     <= state_nxt;
            prev      <= prev_nxt;
            match_cnt <= match_cnt_nxt;
            locked    <= (state_nxt == LOCKED);
            err       <= err_nxt;
            if (err_nxt) begin
                err_sticky <= 1'b1;
                last_bad   <= value;
            end
        end
    end

    sat_counter #(
        .W (ERR_W)
    ) u_err_cnt (
        .clk   (clk),
        .clr_n (reset),
        .inc   (err_nxt),
        .count (err_count)
    );

`ifdef COUNTER_CHECKER_WRAP_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            wrap_count <= '0;
        end else if (wrap_hit) begin
            wrap_count <= wrap_count + 16'd1;
        end
    end
`else
    logic unused_wrap;
    assign unused_wrap = wrap_hit;
`endif

endmodule

// File: tb/tb_counter_checker.sv
// Scoreboard bench for counter_checker (WIDTH=8, LOCK_CYCLES=2, ERR_W=8).
module tb_counter_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] value = '0;
    logic       cnt_reset = 1'b0;
    logic       locked, err, err_sticky;
    logic [7:0] err_count, last_bad;
`ifdef COUNTER_CHECKER_WRAP_CNT_EN
    logic [15:0] wrap_count;
`endif

    always #5 clk = ~clk;

    counter_checker #(
        .WIDTH       (8),
        .LOCK_CYCLES (2),
        .ERR_W       (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .cnt_reset  (cnt_reset),
        .locked     (locked),
        .err        (err),
        .err_sticky (err_sticky),
        .err_count  (err_count),
        .last_bad   (last_bad)
`ifdef COUNTER_CHECKER_WRAP_CNT_EN
        ,
        .wrap_count (wrap_count)
`endif
    );

    typedef struct {
        logic        err;
        logic        locked;
        logic        sticky;
        logic [7:0]  cnt;
        logic [7:0]  bad;
        logic [15:0] wraps;
    } exp_t;

    exp_t sb[$];
    exp_t m;
    int   m_state;   // 0 unlocked, 1 acquire, 2 locked, 3 fault
    int   m_prev;
    int   m_match;
    int   vectors = 0;
    int   miscompares = 0;
    logic [7:0] v;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(input logic rst, input logic cr, input logic [7:0] val);
        if (!rst) begin
            m = '{1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 16'd0};
            m_state = 0;
            m_prev  = 0;
            m_match = 0;
        end else begin
            m.err = 1'b0;
            if (cr) begin
                m_state = 1;
                m_match = 0;
                m_prev  = 0;
            end else begin
                if (m_state == 0) begin
                    m_state = 1;
                    m_match = 0;
                end else if (m_state == 1) begin
                    if (int'(val) == (m_prev + 1) % 256) begin
                        m_match++;
                        if (m_match == 2) m_state = 2;
                    end else begin
                        m_match = 0;
                    end
                end else if (m_state == 2) begin
                    if (int'(val) != (m_prev + 1) % 256) begin
                        m.err = 1'b1;
                        m.sticky = 1'b1;
                        m.bad = val;
                        if (m.cnt != 8'hFF) m.cnt = m.cnt + 8'd1;
                        m_state = 3;
                    end else if (m_prev == 255) begin
                        m.wraps = m.wraps + 16'd1;
                    end
                end else begin
                    m_state = 1;
                    m_match = 0;
                end
                m_prev = int'(val);
            end
            m.locked = (m_state == 2);
        end
    endtask

    task automatic step(input logic rst, input logic cr, input logic [7:0] val);
        exp_t e;
        @(negedge clk);
        reset = rst;
        cnt_reset = cr;
        value = val;
        model(rst, cr, val);
        sb.push_back(m);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("err", {31'd0, err}, {31'd0, e.err});
            check("locked", {31'd0, locked}, {31'd0, e.locked});
            check("err_sticky", {31'd0, err_sticky}, {31'd0, e.sticky});
            check("err_count", {24'd0, err_count}, {24'd0, e.cnt});
            check("last_bad", {24'd0, last_bad}, {24'd0, e.bad});
`ifdef COUNTER_CHECKER_WRAP_CNT_EN
            check("wrap_count", {16'd0, wrap_count}, {16'd0, e.wraps});
`endif
        end
    endtask

    initial begin
        m = '{1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 16'd0};
        m_state = 0; m_prev = 0; m_match = 0;

        // Reset, then free-running count 0..4: lock after third sample.
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        check("rst_locked", {31'd0, locked}, 32'd0);
        check("rst_err_count", {24'd0, err_count}, 32'd0);
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h01);
        check("pre_lock", {31'd0, locked}, 32'd0);
        step(1'b1, 1'b0, 8'h02);
        check("lock_edge3", {31'd0, locked}, 32'd1);
        step(1'b1, 1'b0, 8'h03);
        step(1'b1, 1'b0, 8'h04);
        check("free_no_err", {31'd0, err_sticky}, 32'd0);

        // Skip from 0x10 to 0x12.
        for (int unsigned i = 5; i <= 16; i++) step(1'b1, 1'b0, 8'(i));
        step(1'b1, 1'b0, 8'h12);
        check("skip_err", {31'd0, err}, 32'd1);
        check("skip_bad", {24'd0, last_bad}, 32'h12);
        check("skip_cnt", {24'd0, err_count}, 32'd1);
        check("skip_sticky", {31'd0, err_sticky}, 32'd1);
        check("skip_unlock", {31'd0, locked}, 32'd0);
        step(1'b1, 1'b0, 8'h13);
        check("skip_pulse_end", {31'd0, err}, 32'd0);
        step(1'b1, 1'b0, 8'h14);
        check("skip_no_relock_yet", {31'd0, locked}, 32'd0);
        step(1'b1, 1'b0, 8'h15);
        check("skip_relock", {31'd0, locked}, 32'd1);

        // Wrap through 0xFF -> 0x00 while locked.
        for (int unsigned i = 8'h16; i <= 8'hFF; i++) step(1'b1, 1'b0, 8'(i));
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h01);
        check("wrap_no_err", {24'd0, err_count}, 32'd1);
        check("wrap_locked", {31'd0, locked}, 32'd1);
`ifdef COUNTER_CHECKER_WRAP_CNT_EN
        check("wrap_one", {16'd0, wrap_count}, 32'd1);
`endif

        // Observed counter reset while locked at 0x2A.
        for (int unsigned i = 2; i <= 8'h2A; i++) step(1'b1, 1'b0, 8'(i));
        step(1'b1, 1'b1, 8'h2B);
        check("cr_no_err", {31'd0, err}, 32'd0);
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h01);
        step(1'b1, 1'b0, 8'h02);
        check("cr_relock", {31'd0, locked}, 32'd1);
        check("cr_cnt", {24'd0, err_count}, 32'd1);

        // Held value, then saturate the error counter.
        step(1'b0, 1'b0, 8'h00);
        for (int unsigned i = 0; i <= 5; i++) step(1'b1, 1'b0, 8'(i));
        step(1'b1, 1'b0, 8'h05);
        check("hold_err", {31'd0, err}, 32'd1);
        check("hold_cnt", {24'd0, err_count}, 32'd1);
        v = 8'h06;
        for (int unsigned n = 0; n < 255; n++) begin
            step(1'b1, 1'b0, v);
            step(1'b1, 1'b0, v + 8'd1);
            step(1'b1, 1'b0, v + 8'd2);
            step(1'b1, 1'b0, v + 8'd2);
            v = v + 8'd3;
        end
        check("sat_cnt", {24'd0, err_count}, 32'hFF);
        step(1'b1, 1'b0, v);
        step(1'b1, 1'b0, v + 8'd1);
        step(1'b1, 1'b0, v + 8'd2);
        step(1'b1, 1'b0, v + 8'd2);
        check("sat_hold", {24'd0, err_count}, 32'hFF);

        // Reset while in FAULT clears everything.
        step(1'b0, 1'b0, v + 8'd3);
        check("mid_rst_sticky", {31'd0, err_sticky}, 32'd0);
        check("mid_rst_err", {31'd0, err}, 32'd0);
        check("mid_rst_cnt", {24'd0, err_count}, 32'd0);
        check("mid_rst_bad", {24'd0, last_bad}, 32'd0);
        step(1'b1, 1'b0, 8'h40);
        step(1'b1, 1'b0, 8'h41);
        step(1'b1, 1'b0, 8'h42);
        check("post_rst_lock", {31'd0, locked}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
